// File: rtl/mem_ctrl_pkg.sv
// Shared types and defaults for the MEM-stage SRAM access sequencer.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  localparam int unsigned SRAM_LATENCY_DEF = 6;
  localparam int unsigned ADDR_BASE_DEF    = 1024;
  localparam int unsigned SRAM_AW_DEF      = 18;

  function automatic int unsigned cnt_width(int unsigned latency);
    return $clog2(latency);
  endfunction

  localparam int unsigned CNT_W_DEF = cnt_width(SRAM_LATENCY_DEF);

endpackage

// File: rtl/sram_wait_counter.sv
// Loadable up-counter that flags the last wait cycle of an SRAM access.
module sram_wait_counter
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned SRAM_LATENCY = SRAM_LATENCY_DEF,
  parameter int unsigned CntW         = cnt_width(SRAM_LATENCY)
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic load_i,
  input  logic inc_i,
  output logic tc_o
);

  localparam logic [CntW-1:0] TcVal = CntW'(SRAM_LATENCY - 1);

  logic [CntW-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (load_i) begin
      count_d = CntW'(1);
    end else if (inc_i) begin
      count_d = count_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = (count_q == TcVal);

endmodule

// File: rtl/mem_stage_sram_ctrl.sv
// MEM-stage data-memory sequencer: holds ready low for a fixed-length SRAM access
// so the hazard logic can freeze the pipeline around it.
module mem_stage_sram_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned SRAM_LATENCY = SRAM_LATENCY_DEF,
  parameter int unsigned ADDR_BASE    = ADDR_BASE_DEF,
  parameter int unsigned SRAM_AW      = SRAM_AW_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic               rd_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [31:0]        sram_dq_out,
  output logic               sram_dq_oe,
  input  logic [31:0]        sram_dq_in,
  output logic               sram_we_n
);

  state_e             state_d, state_q;
  logic               is_write_d, is_write_q;
  logic [31:0]        read_data_d, read_data_q;
  logic [SRAM_AW-1:0] sram_addr_d, sram_addr_q;
  logic [31:0]        sram_dq_out_d, sram_dq_out_q;
  logic               sram_dq_oe_d, sram_dq_oe_q;
  logic               sram_we_n_d, sram_we_n_q;

  logic req;
  logic cnt_load, cnt_inc, cnt_clr, cnt_tc;

  assign req      = rd_en | wr_en;
  assign cnt_load = (state_q == StIdle) & req;
  assign cnt_inc  = (state_q == StAccess) & ~cnt_tc;
  assign cnt_clr  = (state_q == StAccess) & cnt_tc;

  sram_wait_counter #(
    .SRAM_LATENCY (SRAM_LATENCY)
  ) u_wait_cnt (
    .clk_i  (clk),
    .rst_i  (rst),
    .clr_i  (cnt_clr),
    .load_i (cnt_load),
    .inc_i  (cnt_inc),
    .tc_o   (cnt_tc)
  );

  always_comb begin
    state_d       = state_q;
    is_write_d    = is_write_q;
    read_data_d   = read_data_q;
    sram_addr_d   = sram_addr_q;
    sram_dq_out_d = sram_dq_out_q;
    sram_dq_oe_d  = sram_dq_oe_q;
    sram_we_n_d   = sram_we_n_q;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          // Write wins when both enables are set; strobes go live on entry to ACCESS.
          is_write_d    = wr_en;
          sram_addr_d   = SRAM_AW'((address - ADDR_BASE) >> 2);
          sram_dq_out_d = write_data;
          sram_we_n_d   = ~wr_en;
          sram_dq_oe_d  = wr_en;
          state_d       = StAccess;
        end
      end
      StAccess: begin
        if (cnt_tc) begin
          if (!is_write_q) begin
            read_data_d = sram_dq_in;
          end
          sram_we_n_d  = 1'b1;
          sram_dq_oe_d = 1'b0;
          state_d      = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      is_write_q    <= 1'b0;
      read_data_q   <= '0;
      sram_addr_q   <= '0;
      sram_dq_out_q <= '0;
      sram_dq_oe_q  <= 1'b0;
      sram_we_n_q   <= 1'b1;
    end else begin
      state_q       <= state_d;
      is_write_q    <= is_write_d;
      read_data_q   <= read_data_d;
      sram_addr_q   <= sram_addr_d;
      sram_dq_out_q <= sram_dq_out_d;
      sram_dq_oe_q  <= sram_dq_oe_d;
      sram_we_n_q   <= sram_we_n_d;
    end
  end

  assign ready       = (state_q == StDone) | ((state_q == StIdle) & ~rd_en & ~wr_en);
  assign read_data   = read_data_q;
  assign sram_addr   = sram_addr_q;
  assign sram_dq_out = sram_dq_out_q;
  assign sram_dq_oe  = sram_dq_oe_q;
  assign sram_we_n   = sram_we_n_q;

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Bench for mem_stage_sram_ctrl: directed scenarios plus randomized accesses checked
// against a cycle-timeline model of one access.
module tb_mem_stage_sram_ctrl;

  localparam int unsigned L    = 6;
  localparam int unsigned BASE = 1024;
  localparam int unsigned AW   = 18;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic [31:0]   address = '0;
  logic [31:0]   write_data = '0;
  logic [31:0]   read_data;
  logic          ready;
  logic [AW-1:0] sram_addr;
  logic [31:0]   sram_dq_out;
  logic          sram_dq_oe;
  logic [31:0]   sram_dq_in = '0;
  logic          sram_we_n;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_rd = '0;

  always #5 clk = ~clk;

  mem_stage_sram_ctrl #(
    .SRAM_LATENCY (L),
    .ADDR_BASE    (BASE),
    .SRAM_AW      (AW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .rd_en       (rd_en),
    .address     (address),
    .write_data  (write_data),
    .read_data   (read_data),
    .ready       (ready),
    .sram_addr   (sram_addr),
    .sram_dq_out (sram_dq_out),
    .sram_dq_oe  (sram_dq_oe),
    .sram_dq_in  (sram_dq_in),
    .sram_we_n   (sram_we_n)
  );

  // One complete access: request presented in cycle t, expected timeline t..t+L.
  task automatic do_access(input bit w, input bit r, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] dqin,
                           input bit drop_mid);
    bit            is_w;
    logic [31:0]   word_off;
    logic [AW-1:0] exp_addr;
    logic [31:0]   old_rd;
    is_w     = w;
    old_rd   = model_rd;
    word_off = (addr - BASE) / 4;
    exp_addr = AW'(word_off % (32'd1 << AW));
    @(posedge clk);
    #1;
    wr_en      = w;
    rd_en      = r;
    address    = addr;
    write_data = wdata;
    sram_dq_in = ~dqin;
    for (int i = 0; i <= int'(L); i++) begin
      @(negedge clk);
      checks++;
      if (ready !== (i == int'(L))) begin
        errors++;
        $display("FAIL ready cyc=%0d: got %b want %b", i, ready, (i == int'(L)));
      end
      if (i >= 1 && i <= int'(L) - 1) begin
        checks++;
        if (sram_we_n !== !is_w) begin
          errors++;
          $display("FAIL we_n cyc=%0d: got %b want %b", i, sram_we_n, !is_w);
        end
        checks++;
        if (sram_dq_oe !== is_w) begin
          errors++;
          $display("FAIL dq_oe cyc=%0d: got %b want %b", i, sram_dq_oe, is_w);
        end
        checks++;
        if (sram_addr !== exp_addr) begin
          errors++;
          $display("FAIL sram_addr: got %h want %h (addr %h)", sram_addr, exp_addr, addr);
        end
        checks++;
        if (sram_dq_out !== wdata) begin
          errors++;
          $display("FAIL dq_out: got %h want %h", sram_dq_out, wdata);
        end
      end
      if (i == int'(L)) begin
        if (!is_w) model_rd = dqin;
        checks++;
        if (sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0) begin
          errors++;
          $display("FAIL strobes_done: got we_n=%b oe=%b want we_n=1 oe=0", sram_we_n,
                   sram_dq_oe);
        end
        checks++;
        if (read_data !== model_rd) begin
          errors++;
          $display("FAIL read_data_done: got %h want %h", read_data, model_rd);
        end
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        sram_dq_in = ~dqin;
      end else begin
        checks++;
        if (read_data !== old_rd) begin
          errors++;
          $display("FAIL read_data_hold cyc=%0d: got %h want %h", i, read_data, old_rd);
        end
      end
      if (i == int'(L) - 2) sram_dq_in = dqin;
      if (drop_mid && i == 2) begin
        wr_en = 1'b0;
        rd_en = 1'b0;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (ready !== 1'b1 || sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got ready=%b we_n=%b oe=%b want 1 1 0", ready, sram_we_n,
               sram_dq_oe);
    end
    checks++;
    if (read_data !== 32'h0 || sram_addr !== '0 || sram_dq_out !== 32'h0) begin
      errors++;
      $display("FAIL reset_data: got rd=%h addr=%h dq=%h want 0 0 0", read_data, sram_addr,
               sram_dq_out);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_idle;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (ready !== 1'b1 || sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0 ||
          read_data !== 32'h0) begin
        errors++;
        $display("FAIL idle cyc=%0d: got ready=%b we_n=%b oe=%b rd=%h want 1 1 0 0", i, ready,
                 sram_we_n, sram_dq_oe, read_data);
      end
    end
  endtask

  task automatic test_write;
    do_access(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 32'h0, 1'b0);
  endtask

  task automatic test_read;
    do_access(1'b0, 1'b1, 32'd1028, 32'h0, 32'h12345678, 1'b0);
  endtask

  task automatic test_back_to_back;
    do_access(1'b1, 1'b0, 32'd1032, 32'hCAFEF00D, 32'h0, 1'b0);
    do_access(1'b0, 1'b1, 32'd2048, 32'h0, 32'hA5A55A5A, 1'b0);
    do_access(1'b0, 1'b1, 32'd1028, 32'h0, 32'h0F0F1234, 1'b0);
  endtask

  task automatic test_both_enables;
    do_access(1'b1, 1'b1, 32'd1036, 32'h13579BDF, 32'hFFFF0000, 1'b0);
  endtask

  task automatic test_random;
    for (int n = 0; n < 24; n++) begin
      int unsigned op;
      logic [31:0] addr;
      op = $urandom_range(0, 2);
      if ($urandom_range(0, 1) == 1) addr = $urandom;
      else addr = BASE + 4 * $urandom_range(0, (1 << AW) - 1) + $urandom_range(0, 3);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      do_access(op != 0, op != 1, addr, $urandom, $urandom, $urandom_range(0, 3) == 0);
    end
  endtask

  task automatic test_reset_mid_write;
    @(posedge clk);
    #1;
    wr_en      = 1'b1;
    address    = 32'd1040;
    write_data = 32'h55AA55AA;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (sram_we_n !== 1'b0 || ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_write: got we_n=%b ready=%b want 0 0", sram_we_n, ready);
    end
    rst   = 1'b1;
    wr_en = 1'b0;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    model_rd = 32'h0;
    @(negedge clk);
    checks++;
    if (ready !== 1'b1 || sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_ctrl: got ready=%b we_n=%b oe=%b want 1 1 0", ready, sram_we_n,
               sram_dq_oe);
    end
    checks++;
    if (sram_addr !== '0 || read_data !== 32'h0 || sram_dq_out !== 32'h0) begin
      errors++;
      $display("FAIL rst_mid_data: got addr=%h rd=%h dq=%h want 0 0 0", sram_addr, read_data,
               sram_dq_out);
    end
    do_access(1'b0, 1'b1, 32'd1100, 32'h0, 32'h87654321, 1'b0);
  endtask

  initial begin
    test_reset;
    test_idle;
    test_write;
    test_read;
    test_back_to_back;
    test_both_enables;
    test_random;
    test_reset_mid_write;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage_sram_ctrl.md
Name: mem_stage_sram_ctrl

Overview:
- Multi-cycle data-memory access sequencer for the MEM stage of the 5-stage MIPS pipeline.
- Accepts one read or write request per instruction from the MEM stage.
- Drives an external single-port SRAM for a fixed number of cycles and holds `ready` low for the whole access.
- The hazard/freeze logic uses `~ready` to hold PC, IF/ID, ID/EX, EX/MEM and MEM/WB.

Parameters:
- SRAM_LATENCY, 6: total cycles `ready` stays low per access; legal range is 2 and up.
- ADDR_BASE, 1024: byte address that maps to SRAM word 0.
- SRAM_AW, 18: SRAM word-address width.

Ports:
- clk  in  1  pipeline clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  MEM-stage store request (MEM_W_EN).
- rd_en  in  1  MEM-stage load request (MEM_R_EN).
- address  in  32  byte address from the ALU result.
- write_data  in  32  store data (rt value).
- read_data  out  32  load result, forwarded to the MEM/WB register.
- ready  out  1  access complete, or no request pending.
- sram_addr  out  SRAM_AW  SRAM word address, registered.
- sram_dq_out  out  32  SRAM write data, registered.
- sram_dq_oe  out  1  drive enable for the SRAM data bus.
- sram_dq_in  in  32  SRAM read data.
- sram_we_n  out  1  SRAM write enable, active low.

Behaviour:
- Reset: clk and rst only; rst is synchronous and active-high. Reset values:
  - state = IDLE, counter = 0
  - read_data = 0, sram_addr = 0, sram_dq_out = 0
  - sram_dq_oe = 0, sram_we_n = 1
- FSM states are IDLE, ACCESS and DONE.
- IDLE:
  - If `rd_en | wr_en`: latch the operation (write wins if both are set), `sram_addr = (address - ADDR_BASE) >> 2` truncated to SRAM_AW bits, and `sram_dq_out = write_data`; set counter = 1; go to ACCESS.
  - Address arithmetic is modulo 2^32. There is no range check.
- ACCESS:
  - For a write: sram_we_n = 0 and sram_dq_oe = 1 for every ACCESS cycle.
  - For a read: sram_we_n = 1 and sram_dq_oe = 0.
  - Counter increments each cycle.
  - When counter == SRAM_LATENCY-1:
    - read: capture sram_dq_in into read_data at that edge;
    - both: go to DONE and return sram_we_n to 1 and sram_dq_oe to 0 at the same edge.
- DONE: lasts one cycle, then goes to IDLE.
- ready is combinational: `ready = (state == DONE) | (state == IDLE & ~rd_en & ~wr_en)`.
- Latency: request first seen in cycle t, then:
  - ready = 0 in cycles t through t+SRAM_LATENCY-1;
  - ready = 1 in cycle t+SRAM_LATENCY;
  - the pipeline advances at the end of that cycle.
- Back-to-back: the next request is evaluated in the IDLE cycle after DONE. That gives one cycle of ready = 0 and no dead ready = 1 cycle between accesses.
- read_data holds its value until the next read completes. Writes never alter it.
- Request inputs must be stable while ready = 0. If they drop mid-ACCESS, the access still completes; the block never aborts.
- rst in any state, including mid-ACCESS, forces the reset values on the next edge. An in-progress write is truncated (sram_we_n returns to 1).

Decomposition:
- Package mem_ctrl_pkg holds:
  - the state enum (IDLE, ACCESS, DONE);
  - default constants SRAM_LATENCY_DEF, ADDR_BASE_DEF and SRAM_AW_DEF;
  - the width of the counter, `$clog2(SRAM_LATENCY)`.
- One natural sub-module, sram_wait_counter: a loadable up-counter with a terminal-count flag at SRAM_LATENCY-1. The FSM and the datapath latches stay in the top level.

Test Plan:
- Idle: rd_en = wr_en = 0 for 10 cycles → ready = 1 throughout, sram_we_n = 1, sram_dq_oe = 0, read_data stays 0.
- Write (L=6): wr_en = 1, address = 1024, write_data = 0xDEADBEEF in cycle t → ready = 0 in cycles t..t+5, sram_addr = 0, sram_dq_out = 0xDEADBEEF, sram_we_n = 0 and sram_dq_oe = 1 in cycles t+1..t+5, ready = 1 in cycle t+6.
- Read: rd_en = 1, address = 1028, sram_dq_in = 0x12345678 → sram_addr = 1, sram_we_n stays 1, read_data = 0x12345678 in cycle t+6 with ready = 1.
- Back-to-back: write to 1032 then read from 2048 → second access starts in cycle t+7, sram_addr = 256, second ready pulse in cycle t+13, read_data unchanged across the write.
- Reset mid-write: rst = 1 while counter = 3 → next cycle state = IDLE, sram_we_n = 1, sram_dq_oe = 0, sram_addr = 0, read_data = 0.
- Both enables set: rd_en = wr_en = 1 at address 1036 → write performed (sram_we_n = 0 during ACCESS), read_data not updated.
